fir: RTL and testbench

11-tap, 32-bit signed, sequential-MAC FIR filter. Coefficients, data length and control/status are programmed over AXI4-Lite. Samples enter on an AXI-Stream slave and results leave on an AXI-Stream master. Taps and the sample history live in two external single-port `bram11` instances driven through dedicated RAM ports.

---
 rtl/fir_pkg.sv | 32 +++
 rtl/fir_bram11.sv | 34 +++
 rtl/fir.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_fir.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: register map, tap count, engine states and helpers
// shared by the FIR engine and its coefficient/history RAMs.
package fir_pkg;

   localparam int TAP_NUM = 11;

   localparam logic [11:0] ADDR_CTRL = 12'h000;
   localparam logic [11:0] ADDR_LEN  = 12'h010;
   localparam logic [11:0] ADDR_TAP  = 12'h020;

   localparam int BIT_START = 0;
   localparam int BIT_DONE  = 1;
   localparam int BIT_IDLE  = 2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_WAIT_IN = 3'd2,
      S_MAC     = 3'd3,
      S_OUT     = 3'd4
   } state_t;

   function automatic logic [11:0] word_addr(input logic [3:0] idx);
      return {6'd0, idx, 2'b00};
   endfunction

   // Coefficient k lives at byte address 0x20 + k.
   function automatic logic tap_hit(input logic [11:0] a);
      return (a[11:4] == ADDR_TAP[11:4]) && (a[3:0] < 4'(TAP_NUM));
   endfunction

endpackage

// File: rtl/fir_bram11.sv
// bram11: 11 x 32 single-port RAM, word index A[5:2],
// one-cycle registered read, byte-lane writes.
module bram11
   import fir_pkg::*;
(
   input  logic        clk,
   input  logic [3:0]  WE,
   input  logic        EN,
   input  logic [31:0] Di,
   input  logic [11:0] A,
   output logic [31:0] Do
);

   logic [31:0] mem [0:TAP_NUM-1];
   logic [3:0]  idx;
   logic        in_range;
   logic        unused_a;

   assign idx      = A[5:2];
   assign in_range = idx < 4'(TAP_NUM);
   assign unused_a = ^{A[11:6], A[1:0]};

   always_ff @(posedge clk) begin
      if (EN) begin
         for (int b = 0; b < 4; b++) begin
            if (WE[b] && in_range) begin
               mem[idx][8*b +: 8] <= Di[8*b +: 8];
            end
         end
         Do <= in_range ? mem[idx] : 32'd0;
      end
   end

endmodule

// File: rtl/fir.sv
// fir: 11-tap sequential-MAC FIR, AXI-Lite control, AXI-Stream I/O.
// Taps and sample history are held in two external bram11 RAMs.
module fir
   import fir_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,

   output logic                   awready,
   output logic                   wready,
   input  logic                   awvalid,
   input  logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   wvalid,
   input  logic [pDATA_WIDTH-1:0] wdata,

   output logic                   arready,
   input  logic                   rready,
   input  logic                   arvalid,
   input  logic [pADDR_WIDTH-1:0] araddr,
   output logic                   rvalid,
   output logic [pDATA_WIDTH-1:0] rdata,

   input  logic                   ss_tvalid,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tlast,
   output logic                   ss_tready,

   input  logic                   sm_tready,
   output logic                   sm_tvalid,
   output logic [pDATA_WIDTH-1:0] sm_tdata,
   output logic                   sm_tlast,

   output logic [3:0]             tap_WE,
   output logic                   tap_EN,
   output logic [pDATA_WIDTH-1:0] tap_Di,
   output logic [pADDR_WIDTH-1:0] tap_A,
   input  logic [pDATA_WIDTH-1:0] tap_Do,

   output logic [3:0]             data_WE,
   output logic                   data_EN,
   output logic [pDATA_WIDTH-1:0] data_Di,
   output logic [pADDR_WIDTH-1:0] data_A,
   input  logic [pDATA_WIDTH-1:0] data_Do
);

   localparam logic [3:0] LAST_TAP = 4'(Tape_Num - 1);
   localparam logic [3:0] TAPS     = 4'(Tape_Num);

   logic rst;
   assign rst = axis_rst_n;

   state_t state;

   logic                   ap_start;
   logic                   ap_done;
   logic                   ap_idle;
   logic [pDATA_WIDTH-1:0] data_length;
   logic [pDATA_WIDTH-1:0] out_cnt;
   logic [pDATA_WIDTH-1:0] acc;
   logic [3:0]             init_cnt;
   logic [3:0]             mac_i;
   logic [3:0]             ptr;
   logic                   mac_vld;
   logic                   rd_pend;

   logic                   wr_go;
   logic                   wr_fire;
   logic                   ar_fire;
   logic                   start_fire;
   logic                   tap_wr;
   logic                   tap_rd;
   logic                   mac_issue;
   logic                   last_out;
   logic [3:0]             hist_idx;
   logic [pDATA_WIDTH-1:0] prod;
   logic [pDATA_WIDTH-1:0] acc_nxt;
   logic [pDATA_WIDTH-1:0] reg_rdata;
   logic                   unused_tlast;

   assign unused_tlast = ss_tlast;

   assign wr_go      = awvalid & wvalid & ~awready;
   assign wr_fire    = awready & awvalid & wvalid;
   assign ar_fire    = arready & arvalid;
   assign start_fire = wr_fire && awaddr == ADDR_CTRL
                       && wdata[BIT_START] && ap_idle;
   assign tap_wr     = wr_fire && tap_hit(awaddr) && ap_idle;
   assign tap_rd     = ar_fire && tap_hit(araddr);

   // An AXI tap read steals the tap port; the MAC waits one cycle.
   assign mac_issue  = state == S_MAC && mac_i <= LAST_TAP && !tap_rd;

   assign hist_idx   = ptr >= mac_i ? ptr - mac_i
                                    : ptr + TAPS - mac_i;
   assign prod       = $signed(tap_Do) * $signed(data_Do);
   assign acc_nxt    = acc + prod;
   assign last_out   = out_cnt + pDATA_WIDTH'(1) == data_length;

   assign ss_tready  = !rst && state == S_WAIT_IN;

   always_comb begin
      reg_rdata = '0;
      unique case (1'b1)
         araddr == ADDR_CTRL: begin
            reg_rdata[BIT_START] = ap_start;
            reg_rdata[BIT_DONE]  = ap_done;
            reg_rdata[BIT_IDLE]  = ap_idle;
         end
         araddr == ADDR_LEN: reg_rdata = data_length;
         default: ;
      endcase
   end

   always_ff @(posedge axis_clk) begin
      if (rst) begin
         awready     <= 1'b0;
         wready      <= 1'b0;
         arready     <= 1'b0;
         rvalid      <= 1'b0;
         rdata       <= '0;
         rd_pend     <= 1'b0;
         data_length <= '0;
      end else begin
         awready <= wr_go;
         wready  <= wr_go;
         arready <= arvalid & ~arready & ~rvalid & ~rd_pend
                    & ~wr_go & ~awready;
         if (wr_fire && awaddr == ADDR_LEN && ap_idle) begin
            data_length <= wdata;
         end
         if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
         if (ar_fire) begin
            if (tap_hit(araddr)) begin
               rd_pend <= 1'b1;
            end else begin
               rdata  <= reg_rdata;
               rvalid <= 1'b1;
            end
         end
         if (rd_pend) begin
            rdata   <= tap_Do;
            rvalid  <= 1'b1;
            rd_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge axis_clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ap_start  <= 1'b0;
         ap_done   <= 1'b0;
         ap_idle   <= 1'b1;
         init_cnt  <= '0;
         mac_i     <= '0;
         ptr       <= '0;
         mac_vld   <= 1'b0;
         acc       <= '0;
         out_cnt   <= '0;
         sm_tvalid <= 1'b0;
         sm_tdata  <= '0;
         sm_tlast  <= 1'b0;
      end else begin
         ap_start <= start_fire;
         if (start_fire) begin
            ap_idle <= 1'b0;
            ap_done <= 1'b0;
         end
         unique case (state)
            S_IDLE: begin
               if (ap_start) begin
                  state    <= S_INIT;
                  init_cnt <= '0;
                  ptr      <= '0;
                  out_cnt  <= '0;
               end
            end
            S_INIT: begin
               init_cnt <= init_cnt + 4'd1;
               if (init_cnt == LAST_TAP) begin
                  state <= S_WAIT_IN;
               end
            end
            S_WAIT_IN: begin
               if (ss_tvalid) begin
                  state   <= S_MAC;
                  mac_i   <= '0;
                  mac_vld <= 1'b0;
                  acc     <= '0;
               end
            end
            S_MAC: begin
               mac_vld <= mac_issue;
               if (mac_issue) begin
                  mac_i <= mac_i + 4'd1;
               end
               if (mac_vld) begin
                  acc <= acc_nxt;
               end
               if (mac_vld && mac_i > LAST_TAP) begin
                  state     <= S_OUT;
                  sm_tvalid <= 1'b1;
                  sm_tdata  <= acc_nxt;
                  sm_tlast  <= last_out;
               end
            end
            S_OUT: begin
               if (sm_tready) begin
                  sm_tvalid <= 1'b0;
                  sm_tlast  <= 1'b0;
                  out_cnt   <= out_cnt + pDATA_WIDTH'(1);
                  ptr       <= ptr == LAST_TAP ? 4'd0 : ptr + 4'd1;
                  if (last_out) begin
                     state   <= S_IDLE;
                     ap_done <= 1'b1;
                     ap_idle <= 1'b1;
                  end else begin
                     state <= S_WAIT_IN;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      tap_EN = 1'b0;
      tap_WE = 4'h0;
      tap_A  = '0;
      tap_Di = '0;
      if (!rst) begin
         unique case (1'b1)
            tap_wr: begin
               tap_EN = 1'b1;
               tap_WE = 4'hF;
               tap_A  = word_addr(awaddr[3:0]);
               tap_Di = wdata;
            end
            tap_rd: begin
               tap_EN = 1'b1;
               tap_A  = word_addr(araddr[3:0]);
            end
            mac_issue: begin
               tap_EN = 1'b1;
               tap_A  = word_addr(mac_i);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      data_EN = 1'b0;
      data_WE = 4'h0;
      data_A  = '0;
      data_Di = '0;
      if (!rst) begin
         unique case (1'b1)
            state == S_INIT: begin
               data_EN = 1'b1;
               data_WE = 4'hF;
               data_A  = word_addr(init_cnt);
            end
            state == S_WAIT_IN && ss_tvalid: begin
               data_EN = 1'b1;
               data_WE = 4'hF;
               data_A  = word_addr(ptr);
               data_Di = ss_tdata;
            end
            mac_issue: begin
               data_EN = 1'b1;
               data_A  = word_addr(hist_idx);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir.sv
// tb_fir: random-stimulus scoreboard bench for fir with two bram11
// instances and a convolution reference model.
module tb_fir;
   import fir_pkg::*;

   logic        axis_clk = 1'b0;
   logic        axis_rst_n;
   logic        awready, wready, awvalid, wvalid;
   logic [11:0] awaddr, araddr;
   logic [31:0] wdata, rdata;
   logic        arready, rready, arvalid, rvalid;
   logic        ss_tvalid, ss_tlast, ss_tready;
   logic [31:0] ss_tdata, sm_tdata;
   logic        sm_tready, sm_tvalid, sm_tlast;
   logic [3:0]  tap_WE, data_WE;
   logic        tap_EN, data_EN;
   logic [31:0] tap_Di, tap_Do, data_Di, data_Do;
   logic [11:0] tap_A, data_A;

   typedef struct packed {
      logic [31:0] y;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   coef[11];
   int   xs[$];
   int   stim[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_out_cyc = -1;
   bit   prev_hs = 0;
   bit   mon_en = 1;
   bit   ready_rand = 0;

   always #5 axis_clk = ~axis_clk;

   fir dut (
      .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
      .awready(awready), .wready(wready), .awvalid(awvalid),
      .awaddr(awaddr), .wvalid(wvalid), .wdata(wdata),
      .arready(arready), .rready(rready), .arvalid(arvalid),
      .araddr(araddr), .rvalid(rvalid), .rdata(rdata),
      .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata),
      .ss_tlast(ss_tlast), .ss_tready(ss_tready),
      .sm_tready(sm_tready), .sm_tvalid(sm_tvalid),
      .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
      .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di),
      .tap_A(tap_A), .tap_Do(tap_Do),
      .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di),
      .data_A(data_A), .data_Do(data_Do)
   );

   bram11 u_tap (
      .clk(axis_clk), .WE(tap_WE), .EN(tap_EN),
      .Di(tap_Di), .A(tap_A), .Do(tap_Do)
   );

   bram11 u_data (
      .clk(axis_clk), .WE(data_WE), .EN(data_EN),
      .Di(data_Di), .A(data_A), .Do(data_Do)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s timeout actual=none required=handshake", name);
   endtask

   // y[n] = sum c[i] * x[n-i], samples before the run start are zero
   function automatic int model_y(input int n);
      int s = 0;
      for (int i = 0; i < 11; i++) begin
         if (n - i >= 0) s += coef[i] * xs[n - i];
      end
      return s;
   endfunction

   task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
      int n = 0;
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
      do begin @(negedge axis_clk); n++; end
      while (!awready && n < 50);
      if (!awready) timeout("axil_write");
      @(negedge axis_clk);
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
      int n = 0;
      d = '0;
      araddr = a; arvalid = 1'b1;
      do begin @(negedge axis_clk); n++; end
      while (!arready && n < 50);
      if (!arready) begin
         timeout("axil_ar");
         arvalid = 1'b0;
         return;
      end
      @(negedge axis_clk);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 50) begin @(negedge axis_clk); n++; end
      if (!rvalid) begin
         timeout("axil_r");
         return;
      end
      d = rdata;
      rready = 1'b1;
      @(negedge axis_clk);
      rready = 1'b0;
   endtask

   task automatic send_sample(input int x);
      int n = 0;
      repeat ($urandom_range(0, 2)) @(negedge axis_clk);
      ss_tdata = x; ss_tlast = 1'($urandom_range(0, 1)); ss_tvalid = 1'b1;
      while (!ss_tready && n < 300) begin @(negedge axis_clk); n++; end
      if (!ss_tready) timeout("ss_tready");
      @(negedge axis_clk);
      ss_tvalid = 1'b0;
   endtask

   task automatic load_taps();
      logic [31:0] d;
      for (int k = 0; k < 11; k++) axil_write(12'h020 + 12'(k), coef[k]);
      for (int k = 0; k < 11; k++) begin
         axil_read(12'h020 + 12'(k), d);
         check($sformatf("tap_rb%0d", k), d, coef[k]);
      end
   endtask

   task automatic run_stream(input int len, input bit mid);
      logic [31:0] d;
      int n = 0;
      xs.delete();
      last_out_cyc = -1;
      axil_write(ADDR_LEN, len);
      axil_write(ADDR_CTRL, 32'h1);
      for (int k = 0; k < len; k++) begin
         xs.push_back(stim[k]);
         exp_q.push_back('{y: model_y(k), last: (k == len - 1)});
         send_sample(stim[k]);
         if (mid && k == 4) begin
            axil_read(ADDR_CTRL, d);
            check("busy_status", d & 32'hF, 32'h0);
            axil_read(12'h025, d);
            check("busy_tap_rd", d, coef[5]);
            axil_write(ADDR_LEN, 32'd999);
            axil_write(12'h020, 32'd12345);
         end
      end
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge axis_clk); n++;
      end
      if (exp_q.size() != 0) begin
         timeout("outputs");
         exp_q.delete();
      end
      repeat (2) @(negedge axis_clk);
      axil_read(ADDR_CTRL, d);
      check("done_status", d, 32'h6);
      axil_read(ADDR_CTRL, d);
      check("done_sticky", d, 32'h6);
      if (mid) begin
         axil_read(ADDR_LEN, d);
         check("busy_len_ignored", d, len);
         axil_read(12'h020, d);
         check("busy_tap_ignored", d, coef[0]);
      end
   endtask

   initial begin : monitor
      exp_t e;
      sm_tready = 1'b1;
      forever begin
         @(negedge axis_clk);
         cyc++;
         if (mon_en && prev_hs) check("valid_one_cycle", sm_tvalid, 1'b0);
         prev_hs = 0;
         sm_tready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (mon_en && sm_tvalid && sm_tready) begin
            prev_hs = 1;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%0h required=none",
                        sm_tdata);
            end else begin
               e = exp_q.pop_front();
               check("y", sm_tdata, e.y);
               check("tlast", sm_tlast, e.last);
               if (last_out_cyc >= 0) begin
                  checks++;
                  if (cyc - last_out_cyc < 12) begin
                     failures++;
                     $display("FAIL out_spacing actual=%0d required>=12",
                              cyc - last_out_cyc);
                  end
               end
               last_out_cyc = cyc;
            end
         end
      end
   end

   initial begin : stimulus
      logic [31:0] d;
      int ref_taps[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
      axis_rst_n = 1'b1;
      awvalid = 0; wvalid = 0; awaddr = 0; wdata = 0;
      arvalid = 0; araddr = 0; rready = 0;
      ss_tvalid = 0; ss_tdata = 0; ss_tlast = 0;
      repeat (4) @(negedge axis_clk);
      check("rst_ss_tready", ss_tready, 1'b0);
      check("rst_sm_tvalid", sm_tvalid, 1'b0);
      check("rst_tap_en", tap_EN, 1'b0);
      check("rst_data_en", data_EN, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      axis_rst_n = 1'b0;
      @(negedge axis_clk);

      axil_read(ADDR_CTRL, d); check("rst_ctrl", d, 32'h4);
      axil_read(ADDR_LEN, d);  check("rst_len", d, 32'h0);
      axil_read(12'h030, d);   check("unmapped_30", d, 32'h0);
      axil_read(12'h02B, d);   check("unmapped_2b", d, 32'h0);

      coef = ref_taps;
      load_taps();

      // impulse: outputs reproduce the taps
      stim.delete();
      stim.push_back(1);
      repeat (10) stim.push_back(0);
      run_stream(11, 1'b1);

      // step: running sum of the taps
      stim.delete();
      repeat (20) stim.push_back(1);
      ready_rand = 1;
      run_stream(20, 1'b0);

      stim.delete();
      stim.push_back(int'($urandom));
      run_stream(1, 1'b0);

      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 11; k++) coef[k] = int'($urandom);
         load_taps();
         stim.delete();
         repeat (25) stim.push_back(int'($urandom));
         run_stream($urandom_range(2, 25), 1'b0);
      end

      // reset in the middle of a run
      axil_write(ADDR_LEN, 32'd30);
      axil_write(ADDR_CTRL, 32'h1);
      mon_en = 0;
      repeat (3) send_sample(int'($urandom));
      axis_rst_n = 1'b1;
      @(negedge axis_clk);
      check("midrst_ss_tready", ss_tready, 1'b0);
      check("midrst_sm_tvalid", sm_tvalid, 1'b0);
      check("midrst_tap_en", tap_EN, 1'b0);
      axis_rst_n = 1'b0;
      exp_q.delete();
      prev_hs = 0;
      mon_en = 1;
      @(negedge axis_clk);
      axil_read(ADDR_CTRL, d); check("midrst_ctrl", d, 32'h4);
      axil_read(ADDR_LEN, d);  check("midrst_len", d, 32'h0);

      for (int k = 0; k < 11; k++) coef[k] = int'($urandom_range(0, 400)) - 200;
      load_taps();
      stim.delete();
      repeat (15) stim.push_back(int'($urandom));
      run_stream(15, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
